keypad_scanner: RTL

//  Scans a 4x4 matrix keypad, debounces the input and encodes the key.

---
 rtl/keypad_scanner.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one row at a time, debounces the
//   column returns and emits one key_valid strobe per accepted press with the
//   key code on key_pressed. Codes follow the downstream key classifier:
//      row 0: 1 2 3 A   row 1: 4 5 6 B   row 2: 7 8 9 C   row 3: E 0 F D
//
//   Optional feature macro: KEYPAD_REPEAT_EN
//      defined   - a held key re-emits key_valid after REPEAT_DELAY ticks and
//                  then every REPEAT_RATE ticks while it stays held.
//      undefined - exactly one key_valid per press.
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  synchronous active-high reset
//   col_in       in   4  keypad columns, active-low, asynchronous
//   row_out      out  4  row drive, active-low, exactly one bit low
//   key_pressed  out  4  code of the last accepted key (held until next)
//   key_valid    out  1  one-cycle strobe, key_pressed is new this cycle
//   key_held     out  1  high from acceptance until release is debounced
// ---------------------------------------------------------------------------
module keypad_scanner #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_TICKS = 20,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_RATE    = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_pressed,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE_TICKS);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   // Out-of-range parameters are caught at elaboration time.
   if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("keypad_scanner: parameter out of range");
   end

   // Active-low one-hot row drive for a row index.
   function automatic logic [3:0] row_drive(input logic [1:0] idx);
      logic [3:0] drv;
      case (idx)
         2'd0:    drv = 4'b1110;
         2'd1:    drv = 4'b1101;
         2'd2:    drv = 4'b1011;
         2'd3:    drv = 4'b0111;
         default: drv = 4'b1110;
      endcase
      return drv;
   endfunction

   // True when exactly one column is pulled low.
   function automatic logic is_single(input logic [3:0] cols);
      logic one;
      case (cols)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: one = 1'b1;
         default:                            one = 1'b0;
      endcase
      return one;
   endfunction

   // Index of the low column; only meaningful when is_single() holds.
   function automatic logic [1:0] col_index(input logic [3:0] cols);
      logic [1:0] idx;
      case (cols)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Classifier code for a (row, col) position.
   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = 4'hA;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = 4'hB;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = 4'hC;
         4'hC:    code = 4'hE;
         4'hD:    code = 4'h0;
         4'hE:    code = 4'hF;
         4'hF:    code = 4'hD;
         default: code = 4'h0;
      endcase
      return code;
   endfunction

   logic [3:0]       sync1_r;
   logic [3:0]       sync2_r;
   logic [DIV_W-1:0] div_cnt_r;
   state_t           state_r;
   logic [1:0]       row_idx_r;
   logic [1:0]       lat_col_r;
   logic [DEB_W-1:0] deb_cnt_r;
   logic [DEB_W-1:0] rel_cnt_r;

   logic             tick_s;
   logic             single_s;
   logic             none_s;
   logic [1:0]       col_idx_s;
   logic [1:0]       row_next_s;
   logic [DEB_W-1:0] deb_inc_s;
   logic [DEB_W-1:0] rel_inc_s;

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam logic [REP_W-1:0] REP_DELAY_T = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] REP_RATE_T  = REP_W'(REPEAT_RATE);

   logic [REP_W-1:0] rep_cnt_r;
   logic             rep_armed_r;   // first repeat already emitted
   logic [REP_W-1:0] rep_inc_s;

   assign rep_inc_s = rep_cnt_r + REP_W'(1);
`endif

   // Two-flop synchronizer for the asynchronous column inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 4'b1111;
         sync2_r <= 4'b1111;
      end else begin
         sync1_r <= col_in;
         sync2_r <= sync1_r;
      end
   end

   // Free-running scan tick divider.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_r <= '0;
      end else if (div_cnt_r == DIV_LAST) begin
         div_cnt_r <= '0;
      end else begin
         div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
   end

   // Classification of the synchronized columns and counter increments.
   always_comb begin
      tick_s     = (div_cnt_r == DIV_LAST);
      single_s   = is_single(sync2_r);
      none_s     = (sync2_r == 4'b1111);
      col_idx_s  = col_index(sync2_r);
      row_next_s = row_idx_r + 2'd1;
      deb_inc_s  = deb_cnt_r + DEB_W'(1);
      rel_inc_s  = rel_cnt_r + DEB_W'(1);
   end

   // Scan/debounce/hold state machine with registered outputs. The row drive
   // is registered here, so a new row appears the cycle after the tick and
   // has a full tick period to settle before the next sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= SCAN;
         row_idx_r   <= 2'd0;
         lat_col_r   <= 2'd0;
         deb_cnt_r   <= '0;
         rel_cnt_r   <= '0;
         row_out     <= 4'b1110;
         key_pressed <= 4'h0;
         key_valid   <= 1'b0;
         key_held    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt_r   <= '0;
         rep_armed_r <= 1'b0;
`endif
      end else begin
         key_valid <= 1'b0;
         if (tick_s) begin
            case (state_r)
               SCAN: begin
                  if (single_s) begin
                     // Row stays driven so the same key keeps being sampled.
                     lat_col_r <= col_idx_s;
                     deb_cnt_r <= DEB_W'(1);
                     if (DEBOUNCE_TICKS == 1) begin
                        key_pressed <= key_code(row_idx_r, col_idx_s);
                        key_valid   <= 1'b1;
                        key_held    <= 1'b1;
                        rel_cnt_r   <= '0;
                        state_r     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_r   <= '0;
                        rep_armed_r <= 1'b0;
`endif
                     end else begin
                        state_r <= DEBOUNCE;
                     end
                  end else begin
                     row_idx_r <= row_next_s;
                     row_out   <= row_drive(row_next_s);
                  end
               end

               DEBOUNCE: begin
                  if (single_s && (col_idx_s == lat_col_r)) begin
                     deb_cnt_r <= deb_inc_s;
                     if (deb_inc_s == DEB_TARGET) begin
                        key_pressed <= key_code(row_idx_r, lat_col_r);
                        key_valid   <= 1'b1;
                        key_held    <= 1'b1;
                        rel_cnt_r   <= '0;
                        state_r     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_r   <= '0;
                        rep_armed_r <= 1'b0;
`endif
                     end
                  end else begin
                     // Bounce, multi-key or a different column: start over.
                     deb_cnt_r <= '0;
                     state_r   <= SCAN;
                     row_idx_r <= row_next_s;
                     row_out   <= row_drive(row_next_s);
                  end
               end

               HELD: begin
                  if (none_s) begin
                     rel_cnt_r <= rel_inc_s;
                     if (rel_inc_s == DEB_TARGET) begin
                        key_held  <= 1'b0;
                        rel_cnt_r <= '0;
                        state_r   <= SCAN;
                        row_idx_r <= row_next_s;
                        row_out   <= row_drive(row_next_s);
                     end
                  end else begin
                     rel_cnt_r <= '0;
                  end
`ifdef KEYPAD_REPEAT_EN
                  // First repeat after REPEAT_DELAY held ticks, then every
                  // REPEAT_RATE ticks; any non-single tick restarts the delay.
                  if (single_s) begin
                     if (!rep_armed_r && (rep_inc_s == REP_DELAY_T)) begin
                        key_valid   <= 1'b1;
                        rep_cnt_r   <= '0;
                        rep_armed_r <= 1'b1;
                     end else if (rep_armed_r && (rep_inc_s == REP_RATE_T)) begin
                        key_valid <= 1'b1;
                        rep_cnt_r <= '0;
                     end else begin
                        rep_cnt_r <= rep_inc_s;
                     end
                  end else begin
                     rep_cnt_r   <= '0;
                     rep_armed_r <= 1'b0;
                  end
`endif
               end

               default: begin
                  state_r   <= SCAN;
                  row_idx_r <= 2'd0;
                  row_out   <= 4'b1110;
                  key_held  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
